// File: rtl/run_ctrl.sv
// run_ctrl -- run sequencer for an attached processor.
//
// Purpose:
//   On a go request, holds the processor in start/init for START_CYCLES
//   cycles and then lets it run. The run ends when the processor raises
//   halt or when TIMEOUT run cycles expire. After a halt, the controller
//   can optionally read DUMP_LEN bytes of data memory from DUMP_BASE and
//   stream them out over a valid/ready handshake.
//
// Build option:
//   RUN_CTRL_DUMP_EN  defined   -> FETCH/SEND memory dump after halt
//                     undefined -> halt goes straight to DONE; the dump
//                                  outputs are tied to zero
//
// Ports:
//   CLK          in   clock, all state changes on the rising edge
//   reset_n      in   synchronous active-low reset
//   go           in   request a new run (honoured in IDLE/DONE only)
//   start        out  processor init/reset, high during INIT
//   halt         in   processor done flag, sampled only in RUN
//   mem_addr     out  [7:0] data-memory read address
//   mem_rd       out  data-memory read enable (FETCH only)
//   mem_data     in   [7:0] data-memory read data, combinational from mem_addr
//   dump_data    out  [7:0] readback byte
//   dump_valid   out  dump_data valid
//   dump_ready   in   consumer accepts the byte
//   busy         out  high in every state except IDLE and DONE
//   done         out  run finished (halt or timeout)
//   timeout      out  run aborted without halt
//   cycle_count  out  [15:0] RUN cycles in the current or last run

module run_ctrl #(
  parameter logic [7:0]  START_CYCLES = 8'd2,
  parameter logic [15:0] TIMEOUT      = 16'hFFFF,
  parameter logic [7:0]  DUMP_BASE    = 8'h00,
  parameter logic [7:0]  DUMP_LEN     = 8'd16
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        go,
  output logic        start,
  input  logic        halt,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  dump_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  // Last value of each counter before it triggers a transition.
  localparam logic [7:0]  INIT_LAST = START_CYCLES - 8'd1;
  localparam logic [15:0] RUN_LAST  = TIMEOUT - 16'd1;

`ifdef RUN_CTRL_DUMP_EN
  localparam logic [7:0]  DUMP_LAST = DUMP_LEN - 8'd1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    FETCH = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd5
  } state_t;
`endif

  state_t      state_q;
  logic [7:0]  init_cnt_q;
  logic        start_q;
  logic        busy_q;
  logic        done_q;
  logic        timeout_q;
  logic [15:0] cycle_cnt_q;
  logic [15:0] cycle_cnt_d;

`ifdef RUN_CTRL_DUMP_EN
  logic [7:0]  mem_addr_q;
  logic        mem_rd_q;
  logic [7:0]  dump_data_q;
  logic        dump_valid_q;
  logic [7:0]  index_q;
`endif

  // Saturating increment of the run-cycle counter.
  assign cycle_cnt_d = (cycle_cnt_q == 16'hFFFF) ? cycle_cnt_q : cycle_cnt_q + 16'd1;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      init_cnt_q   <= 8'd0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cycle_cnt_q  <= 16'd0;
`ifdef RUN_CTRL_DUMP_EN
      mem_addr_q   <= 8'd0;
      mem_rd_q     <= 1'b0;
      dump_data_q  <= 8'd0;
      dump_valid_q <= 1'b0;
      index_q      <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (go) begin
            state_q     <= INIT;
            init_cnt_q  <= 8'd0;
            start_q     <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= 16'd0;
`ifdef RUN_CTRL_DUMP_EN
            index_q     <= 8'd0;
`endif
          end
        end

        INIT: begin
          // halt is deliberately not looked at here.
          if (init_cnt_q == INIT_LAST) begin
            state_q <= RUN;
            start_q <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q + 8'd1;
          end
        end

        RUN: begin
          // halt takes priority over an expiring timeout in the same cycle,
          // and the halt cycle itself is not counted.
          if (halt) begin
`ifdef RUN_CTRL_DUMP_EN
            state_q    <= FETCH;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= DUMP_BASE + index_q;
`else
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            cycle_cnt_q <= cycle_cnt_d;
            if (cycle_cnt_q == RUN_LAST) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end
          end
        end

`ifdef RUN_CTRL_DUMP_EN
        FETCH: begin
          // Memory answers combinationally, so one cycle is enough.
          dump_data_q  <= mem_data;
          dump_valid_q <= 1'b1;
          mem_rd_q     <= 1'b0;
          state_q      <= SEND;
        end

        SEND: begin
          if (dump_ready) begin
            dump_valid_q <= 1'b0;
            index_q      <= index_q + 8'd1;
            if (index_q == DUMP_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= FETCH;
              mem_rd_q   <= 1'b1;
              // 8-bit add wraps FF -> 00 naturally.
              mem_addr_q <= DUMP_BASE + index_q + 8'd1;
            end
          end
        end
`endif

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign start       = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_cnt_q;

`ifdef RUN_CTRL_DUMP_EN
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign dump_data   = dump_data_q;
  assign dump_valid  = dump_valid_q;
`else
  assign mem_addr    = 8'd0;
  assign mem_rd      = 1'b0;
  assign dump_data   = 8'd0;
  assign dump_valid  = 1'b0;

  // Dump-side inputs and parameters have no function in this build.
  logic unused_dump;
  assign unused_dump = ^{dump_ready, mem_data, DUMP_BASE, DUMP_LEN};
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- directed self-checking bench for run_ctrl.
// Two instances: A (START_CYCLES=2, TIMEOUT=100, DUMP_BASE=00, DUMP_LEN=16)
// and B (START_CYCLES=1, TIMEOUT=5, DUMP_BASE=FE, DUMP_LEN=4).
// Dump sequences are exercised when RUN_CTRL_DUMP_EN is defined.

module tb_run_ctrl;

  logic        CLK;
  logic        reset_n;

  logic        go_a, halt_a, rdy_a;
  logic        start_a, mem_rd_a, dump_valid_a, busy_a, done_a, timeout_a;
  logic [7:0]  mem_addr_a, mem_data_a, dump_data_a;
  logic [15:0] cycle_count_a;

  logic        go_b, halt_b, rdy_b;
  logic        start_b, mem_rd_b, dump_valid_b, busy_b, done_b, timeout_b;
  logic [7:0]  mem_addr_b, mem_data_b, dump_data_b;
  logic [15:0] cycle_count_b;

  int n_checks;
  int n_errors;

  // Memory models: A holds i+8'h40, B holds i^8'h5A.
  assign mem_data_a = mem_addr_a + 8'h40;
  assign mem_data_b = mem_addr_b ^ 8'h5A;

  run_ctrl #(
    .START_CYCLES(8'd2), .TIMEOUT(16'd100), .DUMP_BASE(8'h00), .DUMP_LEN(8'd16)
  ) u_dut_a (
    .CLK(CLK), .reset_n(reset_n), .go(go_a), .start(start_a), .halt(halt_a),
    .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a),
    .dump_data(dump_data_a), .dump_valid(dump_valid_a), .dump_ready(rdy_a),
    .busy(busy_a), .done(done_a), .timeout(timeout_a), .cycle_count(cycle_count_a)
  );

  run_ctrl #(
    .START_CYCLES(8'd1), .TIMEOUT(16'd5), .DUMP_BASE(8'hFE), .DUMP_LEN(8'd4)
  ) u_dut_b (
    .CLK(CLK), .reset_n(reset_n), .go(go_b), .start(start_b), .halt(halt_b),
    .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b),
    .dump_data(dump_data_b), .dump_valid(dump_valid_b), .dump_ready(rdy_b),
    .busy(busy_b), .done(done_b), .timeout(timeout_b), .cycle_count(cycle_count_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check_val({tag, " start"},       start_a,       0);
    check_val({tag, " mem_rd"},      mem_rd_a,      0);
    check_val({tag, " mem_addr"},    mem_addr_a,    0);
    check_val({tag, " dump_data"},   dump_data_a,   0);
    check_val({tag, " dump_valid"},  dump_valid_a,  0);
    check_val({tag, " busy"},        busy_a,        0);
    check_val({tag, " done"},        done_a,        0);
    check_val({tag, " timeout"},     timeout_a,     0);
    check_val({tag, " cycle_count"}, cycle_count_a, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw_valid;
    logic [7:0] a_exp;
    logic [7:0] d_exp;

    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    go_a = 1'b1; halt_a = 1'b0; rdy_a = 1'b1;
    go_b = 1'b1; halt_b = 1'b0; rdy_b = 1'b0;

    // Reset with go held high: go must be ignored.
    tick();
    tick();
    check_reset_a("rst_a");
    check_val("rst_b busy",  busy_b,  0);
    check_val("rst_b start", start_b, 0);
    go_a = 1'b0; go_b = 1'b0; reset_n = 1'b1;
    tick();
    check_val("post_rst busy_a", busy_a, 0);
    check_val("post_rst busy_b", busy_b, 0);
    $display("reset: A and B idle");

    // ---- A run 1: start pulse, halt ignored in INIT, halt after 37 cycles
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    check_val("a1 start0", start_a, 1);
    check_val("a1 busy0",  busy_a,  1);
    halt_a = 1'b1;
    tick();
    check_val("a1 start1", start_a, 1);
    tick();
    halt_a = 1'b0;
    check_val("a1 start2", start_a, 0);
    check_val("a1 busy2",  busy_a,  1);
    check_val("a1 cnt_run0", cycle_count_a, 0);
    repeat (37) tick();
    check_val("a1 cnt37", cycle_count_a, 37);
    check_val("a1 done_pre", done_a, 0);
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    check_val("a1 cnt_halt", cycle_count_a, 37);
`ifdef RUN_CTRL_DUMP_EN
    check_val("a1 busy_fetch", busy_a, 1);
    for (int i = 0; i < 16; i++) begin
      check_val("a1 mem_rd", mem_rd_a, 1);
      check_val("a1 mem_addr", mem_addr_a, i);
      tick();
      check_val("a1 dump_valid", dump_valid_a, 1);
      check_val("a1 dump_data", dump_data_a, 32'h40 + i);
      check_val("a1 mem_rd_send", mem_rd_a, 0);
      $display("A dump byte %0d: data=%02h", i, dump_data_a);
      tick();
    end
`endif
    check_val("a1 done", done_a, 1);
    check_val("a1 timeout", timeout_a, 0);
    check_val("a1 busy_done", busy_a, 0);
    check_val("a1 cnt_done", cycle_count_a, 37);
    check_val("a1 mem_rd_done", mem_rd_a, 0);
    check_val("a1 valid_done", dump_valid_a, 0);
    tick();
    check_val("a1 done_hold", done_a, 1);
    $display("A run 1: halt, cycle_count=%0d done=%0d", cycle_count_a, done_a);

    // ---- A run 2: timeout at 100, go ignored while busy
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    check_val("a2 done_clr", done_a, 0);
    check_val("a2 cnt_clr", cycle_count_a, 0);
    check_val("a2 start", start_a, 1);
    tick();
    tick();
    n = 0;
    saw_valid = 1'b0;
    while (!done_a && n < 300) begin
      go_a = (n == 10);
      tick();
      n++;
      if (dump_valid_a) saw_valid = 1'b1;
    end
    go_a = 1'b0;
    check_val("a2 run_cycles", n, 100);
    check_val("a2 cnt", cycle_count_a, 100);
    check_val("a2 timeout", timeout_a, 1);
    check_val("a2 done", done_a, 1);
    check_val("a2 busy", busy_a, 0);
    check_val("a2 no_valid", saw_valid, 0);
    $display("A run 2: timeout, cycle_count=%0d", cycle_count_a);

    // ---- A run 3: reset mid-run / mid-dump with an ignored go
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    check_val("a3 timeout_clr", timeout_a, 0);
    tick();
    tick();
    repeat (3) tick();
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    check_val("a3 go_ignored_start", start_a, 0);
    check_val("a3 go_ignored_cnt", cycle_count_a, 4);
`ifdef RUN_CTRL_DUMP_EN
    rdy_a = 1'b0;
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    tick();
    check_val("a3 send_valid", dump_valid_a, 1);
    check_val("a3 send_data", dump_data_a, 32'h40);
    tick();
    check_val("a3 send_hold", dump_valid_a, 1);
`endif
    reset_n = 1'b0;
    go_a = 1'b1;
    tick();
    reset_n = 1'b1;
    go_a = 1'b0;
    check_reset_a("a3 rst");
    tick();
    check_val("a3 idle", busy_a, 0);
    $display("A run 3: reset mid-run, idle");

    // ---- B run 1: one start cycle, halt and timeout coincide
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    check_val("b1 start0", start_b, 1);
    check_val("b1 busy0", busy_b, 1);
    tick();
    check_val("b1 start1", start_b, 0);
    check_val("b1 cnt0", cycle_count_b, 0);
    repeat (4) tick();
    check_val("b1 cnt4", cycle_count_b, 4);
    check_val("b1 done_pre", done_b, 0);
    halt_b = 1'b1;
    tick();
    halt_b = 1'b0;
    check_val("b1 cnt_halt", cycle_count_b, 4);
    check_val("b1 timeout", timeout_b, 0);
`ifdef RUN_CTRL_DUMP_EN
    for (int i = 0; i < 4; i++) begin
      a_exp = 8'hFE + 8'(i);
      d_exp = a_exp ^ 8'h5A;
      check_val("b1 mem_rd", mem_rd_b, 1);
      check_val("b1 mem_addr", mem_addr_b, a_exp);
      tick();
      for (int k = 0; k < 3; k++) begin
        check_val("b1 valid_wait", dump_valid_b, 1);
        check_val("b1 data_wait", dump_data_b, d_exp);
        check_val("b1 rd_wait", mem_rd_b, 0);
        check_val("b1 addr_hold", mem_addr_b, a_exp);
        tick();
      end
      rdy_b = 1'b1;
      check_val("b1 valid_acc", dump_valid_b, 1);
      check_val("b1 data_acc", dump_data_b, d_exp);
      $display("B dump byte %0d: addr=%02h data=%02h", i, a_exp, dump_data_b);
      tick();
      rdy_b = 1'b0;
    end
`endif
    check_val("b1 done", done_b, 1);
    check_val("b1 busy", busy_b, 0);
    check_val("b1 cnt_done", cycle_count_b, 4);
    $display("B run 1: halt, cycle_count=%0d", cycle_count_b);

    // ---- B run 2: timeout at 5
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    check_val("b2 done_clr", done_b, 0);
    tick();
    n = 0;
    while (!done_b && n < 50) begin
      tick();
      n++;
    end
    check_val("b2 run_cycles", n, 5);
    check_val("b2 cnt", cycle_count_b, 5);
    check_val("b2 timeout", timeout_b, 1);
    check_val("b2 mem_rd", mem_rd_b, 0);
    $display("B run 2: timeout, cycle_count=%0d", cycle_count_b);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter START_CYCLES, default 2: number of cycles start is held high per run (legal range 1..255).
REQ-002 Parameter TIMEOUT, default 16'hFFFF: maximum run cycles before abort (legal range 1..16'hFFFF).
REQ-003 Parameter DUMP_BASE, default 8'h00: first data-memory address read back after halt.
REQ-004 Parameter DUMP_LEN, default 8'd16: number of bytes streamed after halt (legal range 1..255).
REQ-005 CLK  input  1  the single clock; all state changes on posedge CLK.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 go  input  1  request a new run; sampled on each posedge.
REQ-008 start  output  1  init/reset to the processor, active high.
REQ-009 halt  input  1  processor done flag.
REQ-010 mem_addr  output  8  data-memory read address.
REQ-011 mem_rd  output  1  data-memory read enable.
REQ-012 mem_data  input  8  data-memory read data, combinational from mem_addr.
REQ-013 dump_data  output  8  readback byte.
REQ-014 dump_valid  output  1  dump_data valid.
REQ-015 dump_ready  input  1  consumer accepts the byte.
REQ-016 busy  output  1  high in every state except IDLE and DONE.
REQ-017 done  output  1  run finished, by halt or by timeout.
REQ-018 timeout  output  1  run aborted without halt.
REQ-019 cycle_count  output  16  number of RUN cycles in the current or last run.

Function
REQ-020 The state machine SHALL have the states IDLE, INIT, RUN, FETCH, SEND and DONE.
REQ-021 IDLE or DONE, go=1 SHALL move to INIT next cycle, clearing done, timeout, cycle_count and the byte index.
REQ-022 go SHALL be ignored while busy=1.
REQ-023 INIT SHALL hold start=1 for exactly START_CYCLES cycles, then move to RUN; start=0 in all other states.
REQ-024 RUN SHALL increment cycle_count each cycle, saturating at 16'hFFFF.
REQ-025 halt SHALL be sampled only in RUN, so halt high during INIT has no effect.
REQ-026 RUN with halt=1 SHALL move to FETCH; cycle_count SHALL not increment on that cycle.
REQ-027 RUN without halt with cycle_count==TIMEOUT-1 SHALL set timeout=1 and move to DONE, skipping the dump.
REQ-028 If halt=1 and the timeout condition occur in the same cycle, halt SHALL win.
REQ-029 FETCH SHALL drive mem_rd=1 and mem_addr=DUMP_BASE+index (mod 256, so addresses wrap from 8'hFF to 8'h00).
REQ-030 FETCH SHALL capture mem_data into dump_data at the clock edge, then move to SEND; this is one cycle.
REQ-031 SEND SHALL hold dump_valid=1 with dump_data stable until dump_ready=1.
REQ-032 On the accepting cycle of SEND, the index SHALL increment; the next state is FETCH, or DONE when index==DUMP_LEN-1.
REQ-033 Dump throughput SHALL be at most one byte per 2 cycles.
REQ-034 mem_rd SHALL be 0 and mem_addr SHALL hold its last value outside FETCH.
REQ-035 DONE SHALL hold done=1 and keep cycle_count and timeout stable until go is accepted.
REQ-036 A go accepted in DONE SHALL clear done in the same cycle that INIT is entered.

Reset
REQ-037 reset_n=0 at a posedge SHALL force IDLE from any state, including mid-INIT, mid-RUN and mid-dump.
REQ-038 Reset values SHALL be: start=0, mem_rd=0, mem_addr=0, dump_data=0, dump_valid=0, busy=0, done=0, timeout=0, cycle_count=0, index=0.
REQ-039 go SHALL be ignored on any cycle where reset_n=0.

Configuration
REQ-040 Macro RUN_CTRL_DUMP_EN defined: FETCH and SEND SHALL be present as specified above.
REQ-041 Macro RUN_CTRL_DUMP_EN undefined: RUN with halt SHALL go directly to DONE, and FETCH/SEND logic SHALL be omitted.
REQ-042 Macro RUN_CTRL_DUMP_EN undefined: mem_rd, mem_addr, dump_data and dump_valid SHALL be tied to 0; dump_ready SHALL be ignored.

Verification
REQ-043 Reset then go pulse, START_CYCLES=2 -> start=1 on exactly the 2 cycles after acceptance, busy=1 from the first of them.
REQ-044 halt raised after 37 RUN cycles, memory[i]=i+8'h40, dump_ready=1 -> cycle_count=37, 16 bytes 8'h40..8'h4F in order, then done=1, timeout=0.
REQ-045 TIMEOUT=100, halt held low -> timeout=1, done=1, cycle_count=100, dump_valid never high.
REQ-046 DUMP_BASE=8'hFE, DUMP_LEN=4, dump_ready low 3 cycles per byte -> addresses FE, FF, 00, 01; each dump_data stable while dump_valid=1 and ready=0.
REQ-047 reset_n=0 during SEND with a second go pulse while busy -> IDLE with all reset values; the mid-run go is ignored.
REQ-048 RUN_CTRL_DUMP_EN undefined, halt after 5 cycles -> DONE the following cycle, mem_rd never asserted.
